periph_bus_ctrl: RTL
====================

# periph_bus_ctrl

Parametrised peripheral bus controller between the processor's memory-mapped I/O port and up to N_SLAVES peripherals (ADC control, keypad, seven-segment, LEDs, switches, timer, ...). It decodes the slot select, issues a registered one-hot write or read strobe to the addressed peripheral, and waits for that peripheral's ready. It returns read data with a ready/error response, and reports unmapped slots, conflicting requests and slave timeouts.

## Interface
Parameters:
- N_SLAVES, 8, number of peripheral slots; SEL_W = $clog2(N_SLAVES) (derived, not overridable)
- DATA_W, 32, data width
- TIMEOUT, 15, maximum ACCESS cycles to wait for slave ready (>=1)
- VALID_MASK, 8'b0111_1101, bit i = 1 means slot i is mapped (default: slots 0,2,3,4,5,6)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- proc_sel  in  SEL_W  target slot
- proc_we  in  1  write request (level)
- proc_re  in  1  read request (level)
- proc_wdata  in  DATA_W  write data
- proc_rdata  out  DATA_W  read data, valid while proc_ready=1
- proc_ready  out  1  one-cycle completion pulse
- proc_err  out  1  error qualifier, valid while proc_ready=1
- busy  out  1  high in any state other than IDLE
- err_sel  out  SEL_W  slot of the most recent errored access (sticky)
- slv_we  out  N_SLAVES  one-hot write strobe
- slv_re  out  N_SLAVES  one-hot read strobe
- slv_wdata  out  DATA_W  latched write data
- slv_rdata  in  N_SLAVES*DATA_W  slot i occupies bits [i*DATA_W +: DATA_W]
- slv_ready  in  N_SLAVES  per-slave ready

## Operation
- Reset values: every output 0; state IDLE; latches and counter 0.
- States:
  - IDLE: requests are sampled only here.
  - ACCESS: strobe asserted, waiting for the addressed slave's ready.
  - RESP: one cycle, proc_ready=1.
- IDLE, request seen:
  - proc_we XOR proc_re with VALID_MASK[proc_sel]=1: latch sel, direction and wdata, then go to ACCESS.
  - proc_we AND proc_re, or VALID_MASK[proc_sel]=0: go to RESP with err=1. No slave strobe is issued and err_sel <= proc_sel.
- ACCESS:
  - slv_we[sel] or slv_re[sel] is held high for the whole state; all other strobe bits are 0.
  - Only slv_ready[sel] is observed; ready from other slots is ignored.
  - slv_ready[sel]=1 → RESP, err=0, proc_rdata <= slv_rdata[sel] on reads (0 on writes).
  - Timeout counter reaches TIMEOUT with no ready → RESP, err=1, proc_rdata=0, err_sel <= sel.
  - If ready and timeout fall on the same edge, ready wins.
- RESP → IDLE unconditionally. proc_rdata and proc_err are cleared on leaving RESP.
- The processor must deassert its request in the cycle after proc_ready. Requests in ACCESS or RESP are ignored and are not queued.
- proc_sel values >= N_SLAVES are treated as unmapped.
- rst_n asserted mid-access clears strobes immediately (asynchronously); no response is issued.

## Timing
- Request sampled at edge E0. Strobe is high from E0 and fully registered, so there is no combinational path from proc_* to slv_*.
- Ready present in the first ACCESS cycle: sampled at E1, proc_ready high in cycle E1–E2. The minimum access takes 2 cycles from request to response; the strobe is 1 cycle wide.
- Timeout: the strobe stays high for exactly TIMEOUT cycles, then proc_ready/proc_err is high for one cycle.
- Error on decode (unmapped or conflicting request): proc_ready at E0+1, i.e. 1-cycle latency.
- Back-to-back accesses: a minimum 1-cycle IDLE gap is required, so throughput is at most 1 access per 3 cycles.

## Structure
- Package periph_bus_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the access-type enum (WR, RD);
  - the default VALID_MASK constant;
  - slot index constants: ADC_CTRL=0, TECLADO=2, SIETE_SEG=3, LEDS=4, SWITCHES=5, TIMER=6.
- Sub-module bus_timeout_ctr: width $clog2(TIMEOUT+1), synchronous clear on entry to ACCESS, increments in ACCESS, and asserts expired at TIMEOUT.
- Read-data selection is an indexed part-select on the latched sel; there is no per-slot logic beyond the strobe one-hot.

## Test plan
- Write slot 4, wdata=0x0000_00A5, slv_ready[4] high immediately: slv_we=8'b0001_0000 for 1 cycle, slv_wdata=0xA5, proc_ready after 2 cycles, proc_err=0.
- Read slot 6, slv_ready[6] high after 3 cycles, slot 6 data 0x1234_5678: slv_re[6] high 4 cycles, proc_rdata=0x1234_5678, proc_err=0.
- Read slot 3, no ready: slv_re[3] high 15 cycles, then proc_ready=1, proc_err=1, proc_rdata=0, err_sel=3.
- Write slot 1 (unmapped), and separately we=re=1 on slot 0: no strobe, proc_ready=1 with proc_err=1 at E0+1, err_sel=1 then 0.
- Hold proc_we through ACCESS, and pulse slv_ready[2] during a slot-5 access: exactly one access occurs and the slot-2 ready is ignored.
- Drop rst_n during ACCESS on slot 0: slv_we/slv_re go 0 immediately, proc_ready never pulses, state is IDLE after release.

Source files
------------

// File: rtl/periph_bus_ctrl_pkg.sv
// Shared types and constants for the peripheral bus controller.
package periph_bus_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Direction of the latched access.
    typedef enum logic {
        WR = 1'b0,
        RD = 1'b1
    } access_e;

    // Slots 0,2,3,4,5,6 are populated on the reference board.
    localparam logic [7:0] DEFAULT_VALID_MASK = 8'b0111_1101;

    // Slot assignment of the board peripherals.
    localparam int ADC_CTRL  = 0;
    localparam int TECLADO   = 2;
    localparam int SIETE_SEG = 3;
    localparam int LEDS      = 4;
    localparam int SWITCHES  = 5;
    localparam int TIMER     = 6;

endpackage

// File: rtl/periph_bus_ctrl_if.sv
// Processor-side request/response and peripheral-side strobe/ready signals.
// The master view belongs to the controller, the slave view to the
// processor plus peripherals that surround it.
interface periph_bus_ctrl_if #(
    parameter int N_SLAVES = 8,
    parameter int DATA_W   = 32
);
    localparam int SEL_W = $clog2(N_SLAVES);

    logic [SEL_W-1:0]           proc_sel;
    logic                       proc_we;
    logic                       proc_re;
    logic [DATA_W-1:0]          proc_wdata;
    logic [DATA_W-1:0]          proc_rdata;
    logic                       proc_ready;
    logic                       proc_err;

    logic [N_SLAVES-1:0]        slv_we;
    logic [N_SLAVES-1:0]        slv_re;
    logic [DATA_W-1:0]          slv_wdata;
    logic [N_SLAVES*DATA_W-1:0] slv_rdata;
    logic [N_SLAVES-1:0]        slv_ready;

    modport master (
        input  proc_sel, proc_we, proc_re, proc_wdata, slv_rdata, slv_ready,
        output proc_rdata, proc_ready, proc_err, slv_we, slv_re, slv_wdata
    );

    modport slave (
        output proc_sel, proc_we, proc_re, proc_wdata, slv_rdata, slv_ready,
        input  proc_rdata, proc_ready, proc_err, slv_we, slv_re, slv_wdata
    );
endinterface

// File: rtl/periph_bus_ctrl_timeout_ctr.sv
// Counts ACCESS cycles; expired flags the cycle that completes TIMEOUT
// cycles of waiting, so the strobe is high for exactly TIMEOUT cycles.
module bus_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    // Cleared on entry to ACCESS, then counts each ACCESS cycle (saturating).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = inc && (cnt_q == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/periph_bus_ctrl.sv
// Peripheral bus controller: decodes the slot, drives a registered one-hot
// strobe, waits for that slot's ready (bounded by TIMEOUT) and returns a
// one-cycle ready/err response to the processor.
module periph_bus_ctrl
    import periph_bus_pkg::*;
#(
    parameter int                  N_SLAVES   = 8,
    parameter int                  DATA_W     = 32,
    parameter int                  TIMEOUT    = 15,
    parameter logic [N_SLAVES-1:0] VALID_MASK = N_SLAVES'(DEFAULT_VALID_MASK),
    localparam int                 SEL_W      = $clog2(N_SLAVES)
) (
    input  logic                clk,
    input  logic                rst_n,
    periph_bus_ctrl_if.master   bus,
    output logic                busy,
    output logic [SEL_W-1:0]    err_sel
);
    state_e              state_q, state_d;
    access_e             dir_q, dir_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [SEL_W-1:0]    err_sel_q, err_sel_d;

    logic                ctr_clr;
    logic                expired;
    logic                mapped;
    logic [N_SLAVES-1:0] sel_onehot;
    logic [DATA_W-1:0]   rd_word;

    assign mapped     = (int'(bus.proc_sel) < N_SLAVES) && VALID_MASK[bus.proc_sel];
    assign sel_onehot = N_SLAVES'(1) << sel_q;
    assign rd_word    = bus.slv_rdata[int'(sel_q)*DATA_W +: DATA_W];

    bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (ctr_clr),
        .inc     (state_q == ACCESS),
        .expired (expired)
    );

    // State and latched access/response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dir_q     <= WR;
            sel_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_sel_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q   <= state_d;
            dir_q     <= dir_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            err_sel_q <= err_sel_d;
        end
    end

    // Next-state decode: accept/reject in IDLE, ready/timeout in ACCESS.
    always_comb begin
        // NOTE: hold-value defaults first so no path leaves a latch behind.
        state_d   = state_q;
        dir_d     = dir_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        err_sel_d = err_sel_q;
        ctr_clr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.proc_we || bus.proc_re) begin
                    if ((bus.proc_we && bus.proc_re) || !mapped) begin
                        state_d   = RESP;
                        err_d     = 1'b1;
                        rdata_d   = '0;
                        err_sel_d = bus.proc_sel;
                    end else begin
                        state_d = ACCESS;
                        sel_d   = bus.proc_sel;
                        dir_d   = bus.proc_we ? WR : RD;
                        wdata_d = bus.proc_wdata;
                        ctr_clr = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Ready takes priority over a coincident timeout.
                if (bus.slv_ready[sel_q]) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = (dir_q == RD) ? rd_word : '0;
                end else if (expired) begin
                    state_d   = RESP;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                    err_sel_d = sel_q;
                end
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come only from registers: no path from proc_* to slv_*.
    assign bus.slv_we     = (state_q == ACCESS && dir_q == WR) ? sel_onehot : '0;
    assign bus.slv_re     = (state_q == ACCESS && dir_q == RD) ? sel_onehot : '0;
    assign bus.slv_wdata  = wdata_q;
    assign bus.proc_ready = (state_q == RESP);
    assign bus.proc_rdata = rdata_q;
    assign bus.proc_err   = err_q;
    assign busy           = (state_q != IDLE);
    assign err_sel        = err_sel_q;
endmodule
